// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32 decode constants, control encodings and the ID/EX control bundle.
// Used by ctrl_decode and decode_ctrl_stage (optional M support: DECODE_M_EXT_EN).
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;
   localparam logic [1:0] ALU_UPPER  = 2'b11;

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       alu_a_src_pc;
      logic       mul_div;
      logic [2:0] imm_src;
      logic [1:0] result_src;
      logic [1:0] alu_op;
   } ctrl_bundle_t;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // funct7=0100000 only encodes sub and sra
   function automatic logic alt_funct7_ok(input logic [2:0] funct3);
      return (funct3 == 3'b000) || (funct3 == 3'b101);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32 main decoder: opcode/funct3/funct7 -> control bundle + illegal flag.
// Macro DECODE_M_EXT_EN makes funct7=0000001 R-type ops legal mul/div ops.
module ctrl_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0]   opcode_i,
   input  logic [2:0]   funct3_i,
   input  logic [6:0]   funct7_i,
   output ctrl_bundle_t ctrl_o,
   output logic         illegal_o
);

   ctrl_bundle_t ctrl_s;
   logic         illegal_s;

   // Raw per-opcode control; R-type funct7 legality checked inline
   always_comb begin
      ctrl_s    = '0;
      illegal_s = 1'b0;
      case (opcode_i)
         OP_LOAD: begin
            ctrl_s.reg_write  = 1'b1;
            ctrl_s.alu_src    = 1'b1;
            ctrl_s.imm_src    = IMM_I;
            ctrl_s.result_src = RES_MEM;
         end
         OP_STORE: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.mem_write = 1'b1;
            ctrl_s.imm_src   = IMM_S;
         end
         OP_R: begin
            ctrl_s.reg_write = 1'b1;
            ctrl_s.alu_op    = ALU_FUNCT;
            case (funct7_i)
               7'b0000000: illegal_s = 1'b0;
               7'b0100000: illegal_s = !alt_funct7_ok(funct3_i);
`ifdef DECODE_M_EXT_EN
               7'b0000001: ctrl_s.mul_div = 1'b1;
`endif
               default:    illegal_s = 1'b1;
            endcase
         end
         OP_I: begin
            ctrl_s.reg_write = 1'b1;
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.imm_src   = IMM_I;
            ctrl_s.alu_op    = ALU_FUNCT;
         end
         OP_BRANCH: begin
            ctrl_s.branch  = 1'b1;
            ctrl_s.imm_src = IMM_B;
            ctrl_s.alu_op  = ALU_BRANCH;
         end
         OP_JAL: begin
            ctrl_s.reg_write  = 1'b1;
            ctrl_s.jump       = 1'b1;
            ctrl_s.imm_src    = IMM_J;
            ctrl_s.result_src = RES_PC4;
         end
         OP_JALR: begin
            ctrl_s.reg_write  = 1'b1;
            ctrl_s.jump       = 1'b1;
            ctrl_s.jalr       = 1'b1;
            ctrl_s.alu_src    = 1'b1;
            ctrl_s.imm_src    = IMM_I;
            ctrl_s.result_src = RES_PC4;
         end
         OP_LUI: begin
            ctrl_s.reg_write = 1'b1;
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.imm_src   = IMM_U;
            ctrl_s.alu_op    = ALU_UPPER;
         end
         OP_AUIPC: begin
            ctrl_s.reg_write    = 1'b1;
            ctrl_s.alu_src      = 1'b1;
            ctrl_s.alu_a_src_pc = 1'b1;
            ctrl_s.imm_src      = IMM_U;
            ctrl_s.alu_op       = ALU_UPPER;
         end
         default: illegal_s = 1'b1;
      endcase
   end

   // Illegal encodings leave every control bit cleared so nothing downstream acts on them
   assign ctrl_o    = illegal_s ? '0 : ctrl_s;
   assign illegal_o = illegal_s;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered RV32 decode stage: valid/ready ID/EX register around ctrl_decode plus mul/div interlock.
// Macro DECODE_M_EXT_EN enables M decode and the busy FSM; otherwise md_busy is tied 0.
module decode_ctrl_stage
   import riscv_ctrl_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int MULDIV_CYCLES = 4
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            RegWrite,
   output logic            ALUSrc,
   output logic            MemWrite,
   output logic            Branch,
   output logic            Jump,
   output logic            Jalr,
   output logic            ALUASrcPC,
   output logic            MulDiv,
   output logic            Illegal,
   output logic [2:0]      ImmSrc,
   output logic [1:0]      ResultSrc,
   output logic [1:0]      ALUOp,
   output logic [2:0]      funct3,
   output logic            funct7b5,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [XLEN-1:0] pc_out,
   output logic            md_busy
);

   if (MULDIV_CYCLES < 1) begin : g_bad_cycles
      $error("decode_ctrl_stage: MULDIV_CYCLES must be >= 1");
   end

   ctrl_bundle_t    dec_s;
   logic            dec_illegal_s;
   ctrl_bundle_t    bundle_q;
   logic            illegal_q;
   logic            out_valid_q;
   logic [2:0]      funct3_q;
   logic            funct7b5_q;
   logic [4:0]      rd_q;
   logic [4:0]      rs1_q;
   logic [4:0]      rs2_q;
   logic [XLEN-1:0] pc_q;
   logic            md_busy_s;
   logic            accept_s;
   logic            handoff_s;

   ctrl_decode u_ctrl_decode (
      .opcode_i  (instr[6:0]),
      .funct3_i  (instr[14:12]),
      .funct7_i  (instr[31:25]),
      .ctrl_o    (dec_s),
      .illegal_o (dec_illegal_s)
   );

   // flush overrides in_ready: the slot is being discarded this cycle
   assign in_ready  = !md_busy_s && (!out_valid_q || out_ready);
   assign accept_s  = in_valid && in_ready && !flush;
   assign handoff_s = out_valid_q && out_ready;

   // ID/EX register: load on accept, drop valid on handoff or flush, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
         illegal_q   <= 1'b0;
         funct3_q    <= 3'b000;
         funct7b5_q  <= 1'b0;
         rd_q        <= 5'd0;
         rs1_q       <= 5'd0;
         rs2_q       <= 5'd0;
         pc_q        <= '0;
      end else if (accept_s) begin
         out_valid_q <= 1'b1;
         bundle_q    <= dec_s;
         illegal_q   <= dec_illegal_s;
         funct3_q    <= instr[14:12];
         funct7b5_q  <= instr[30];
         rd_q        <= instr[11:7];
         rs1_q       <= instr[19:15];
         rs2_q       <= instr[24:20];
         pc_q        <= pc_in;
      end else if (flush || handoff_s) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_q;
      end
   end

`ifdef DECODE_M_EXT_EN
   localparam int CNT_W = $clog2(MULDIV_CYCLES) + 1;

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;

   // Interlock FSM: busy for MULDIV_CYCLES cycles after a mul/div bundle leaves; flush has no say
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            MD_IDLE: begin
               if (handoff_s && bundle_q.mul_div) begin
                  state_q <= MD_BUSY;
                  cnt_q   <= CNT_W'(MULDIV_CYCLES - 1);
               end else begin
                  state_q <= MD_IDLE;
               end
            end
            MD_BUSY: begin
               if (cnt_q == '0) begin
                  state_q <= MD_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= MD_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign md_busy_s = (state_q == MD_BUSY);
`else
   assign md_busy_s = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign md_busy   = md_busy_s;
   assign RegWrite  = bundle_q.reg_write;
   assign ALUSrc    = bundle_q.alu_src;
   assign MemWrite  = bundle_q.mem_write;
   assign Branch    = bundle_q.branch;
   assign Jump      = bundle_q.jump;
   assign Jalr      = bundle_q.jalr;
   assign ALUASrcPC = bundle_q.alu_a_src_pc;
   assign MulDiv    = bundle_q.mul_div;
   assign ImmSrc    = bundle_q.imm_src;
   assign ResultSrc = bundle_q.result_src;
   assign ALUOp     = bundle_q.alu_op;
   assign Illegal   = illegal_q;
   assign funct3    = funct3_q;
   assign funct7b5  = funct7b5_q;
   assign rd        = rd_q;
   assign rs1       = rs1_q;
   assign rs2       = rs2_q;
   assign pc_out    = pc_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: directed cases plus random traffic against a behavioural model.
// Honours DECODE_M_EXT_EN the same way the design does.
module tb_decode_ctrl_stage;

   localparam int MC = 4;
`ifdef DECODE_M_EXT_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   typedef struct packed {
      logic        RegWrite, ALUSrc, MemWrite, Branch, Jump, Jalr, ALUASrcPC, MulDiv, Illegal;
      logic [2:0]  ImmSrc;
      logic [1:0]  ResultSrc;
      logic [1:0]  ALUOp;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] pc;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, md_busy;
   logic [31:0] instr, pc_in, pc_out;
   logic        RegWrite, ALUSrc, MemWrite, Branch, Jump, Jalr, ALUASrcPC, MulDiv, Illegal;
   logic [2:0]  ImmSrc, funct3;
   logic [1:0]  ResultSrc, ALUOp;
   logic        funct7b5;
   logic [4:0]  rd, rs1, rs2;

   int   n_checks = 0;
   int   n_errors = 0;
   logic m_valid;
   obs_t m_cur;
   int   busy_left;

   always #5 clk = ~clk;

   decode_ctrl_stage #(.XLEN(32), .MULDIV_CYCLES(MC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .pc_in(pc_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
      .Jalr(Jalr), .ALUASrcPC(ALUASrcPC), .MulDiv(MulDiv), .Illegal(Illegal), .ImmSrc(ImmSrc),
      .ResultSrc(ResultSrc), .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .rd(rd),
      .rs1(rs1), .rs2(rs2), .pc_out(pc_out), .md_busy(md_busy)
   );

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic obs_t dut_obs();
      obs_t o;
      o.RegWrite = RegWrite; o.ALUSrc = ALUSrc; o.MemWrite = MemWrite; o.Branch = Branch;
      o.Jump = Jump; o.Jalr = Jalr; o.ALUASrcPC = ALUASrcPC; o.MulDiv = MulDiv; o.Illegal = Illegal;
      o.ImmSrc = ImmSrc; o.ResultSrc = ResultSrc; o.ALUOp = ALUOp; o.funct3 = funct3;
      o.funct7b5 = funct7b5; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2; o.pc = pc_out;
      return o;
   endfunction

   // Expected outputs straight from the instruction-class table
   function automatic obs_t model(input logic [31:0] i, input logic [31:0] pc);
      obs_t f = '0;
      obs_t c = '0;
      logic ok = 1'b1;
      logic [6:0] f7 = i[31:25];
      logic [2:0] f3 = i[14:12];
      f.funct3 = f3; f.funct7b5 = i[30]; f.rd = i[11:7]; f.rs1 = i[19:15]; f.rs2 = i[24:20]; f.pc = pc;
      case (i[6:0])
         7'h03: begin c.RegWrite = 1'b1; c.ALUSrc = 1'b1; c.ResultSrc = 2'b01; end
         7'h23: begin c.ALUSrc = 1'b1; c.MemWrite = 1'b1; c.ImmSrc = 3'b001; end
         7'h33: begin
            c.RegWrite = 1'b1; c.ALUOp = 2'b10;
            if (f7 == 7'h00) ok = 1'b1;
            else if (f7 == 7'h20) ok = (f3 == 3'd0) || (f3 == 3'd5);
            else if (f7 == 7'h01) begin ok = M_EN; c.MulDiv = M_EN; end
            else ok = 1'b0;
         end
         7'h13: begin c.RegWrite = 1'b1; c.ALUSrc = 1'b1; c.ALUOp = 2'b10; end
         7'h63: begin c.Branch = 1'b1; c.ImmSrc = 3'b010; c.ALUOp = 2'b01; end
         7'h6F: begin c.RegWrite = 1'b1; c.Jump = 1'b1; c.ImmSrc = 3'b011; c.ResultSrc = 2'b10; end
         7'h67: begin
            c.RegWrite = 1'b1; c.Jump = 1'b1; c.Jalr = 1'b1; c.ALUSrc = 1'b1; c.ResultSrc = 2'b10;
         end
         7'h37: begin c.RegWrite = 1'b1; c.ALUSrc = 1'b1; c.ImmSrc = 3'b100; c.ALUOp = 2'b11; end
         7'h17: begin
            c.RegWrite = 1'b1; c.ALUSrc = 1'b1; c.ALUASrcPC = 1'b1; c.ImmSrc = 3'b100; c.ALUOp = 2'b11;
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         c = '0;
         c.Illegal = 1'b1;
      end
      return f | c;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [0:8];
      logic [6:0]  f7s [0:2];
      logic [31:0] i;
      int k;
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      f7s = '{7'h00, 7'h20, 7'h01};
      i = $urandom;
      k = int'($urandom_range(0, 9));
      i[6:0] = (k == 9) ? 7'($urandom) : ops[k];
      if (i[6:0] == 7'h33) begin
         k = int'($urandom_range(0, 3));
         i[31:25] = (k == 3) ? 7'($urandom) : f7s[k];
      end
      return i;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_cur = '0;
      busy_left = 0;
   endtask

   // One clock: drive at posedge+1, compare at negedge, advance the model, return at next posedge+1
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic rdy, input logic fl);
      logic hand, acc, mrdy;
      in_valid = v; instr = ins; pc_in = p; out_ready = rdy; flush = fl;
      @(negedge clk);
      mrdy = (busy_left == 0) && (!m_valid || rdy);
      check("out_valid", out_valid, m_valid);
      check("md_busy", md_busy, busy_left > 0);
      check("in_ready", in_ready, mrdy);
      check("bundle", dut_obs(), m_cur);
      hand = m_valid && rdy;
      acc = v && mrdy && !fl;
      if (busy_left > 0) busy_left--;
      else if (hand && m_cur.MulDiv) busy_left = MC;
      if (acc) begin
         m_valid = 1'b1;
         m_cur = model(ins, p);
      end else if (fl || hand) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      logic v, rdy, fl;
      rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; pc_in = 32'd0; out_ready = 1'b0; flush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_md_busy", md_busy, 1'b0);
      check("rst_bundle", dut_obs(), 96'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      cycle(1'b1, 32'h00812283, 32'h100, 1'b1, 1'b0);
      check("ld_valid", out_valid, 1'b1);
      check("ld_ctrl", {RegWrite, ALUSrc, ResultSrc, ImmSrc}, {1'b1, 1'b1, 2'b01, 3'b000});
      check("ld_regs", {rd, rs1}, {5'd5, 5'd2});

      cycle(1'b1, 32'h003100B3, 32'h104, 1'b1, 1'b0);
      check("add_aluop", {out_valid, ALUOp}, {1'b1, 2'b10});
      cycle(1'b1, 32'h000000EF, 32'h108, 1'b1, 1'b0);
      check("jal_ctrl", {out_valid, Jump, ResultSrc, ImmSrc}, {1'b1, 1'b1, 2'b10, 3'b011});
      cycle(1'b1, 32'h00001097, 32'h10C, 1'b1, 1'b0);
      check("auipc_ctrl", {out_valid, ALUASrcPC, ImmSrc}, {1'b1, 1'b1, 3'b100});

      cycle(1'b1, 32'h00000000, 32'h110, 1'b1, 1'b0);
      check("ill0_flag", {out_valid, Illegal}, {1'b1, 1'b1});
      check("ill0_ctrl", {RegWrite, ALUSrc, MemWrite, Branch, Jump, Jalr, ALUASrcPC, MulDiv,
                          ImmSrc, ResultSrc, ALUOp}, 96'd0);
      cycle(1'b1, 32'h403170B3, 32'h114, 1'b1, 1'b0);
      check("ill1_flag", {out_valid, Illegal}, {1'b1, 1'b1});
      check("ill1_ctrl", {RegWrite, ALUSrc, MemWrite, Branch, Jump, Jalr, ALUASrcPC, MulDiv,
                          ImmSrc, ResultSrc, ALUOp}, 96'd0);

      cycle(1'b1, 32'h00208133, 32'h200, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 32'h00500093, 32'h204, 1'b0, 1'b0);
         check("stall_valid", out_valid, 1'b1);
         check("stall_pc", pc_out, 32'h200);
         check("stall_ready", in_ready, 1'b0);
      end
      cycle(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b1);
      check("flush_valid", out_valid, 1'b0);
      check("flush_noacc", pc_out, 32'h200);

      cycle(1'b1, 32'h023100B3, 32'h400, 1'b1, 1'b0);
      check("mul_flags", {MulDiv, Illegal}, {M_EN, !M_EN});
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (in_ready == 1'b0) cnt++;
         cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      end
      check("md_cycles", cnt, M_EN ? MC : 0);

      cycle(1'b1, 32'h023100B3, 32'h500, 1'b1, 1'b0);
      cycle(1'b1, 32'h003100B3, 32'h504, 1'b1, 1'b0);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("arst_md_busy", md_busy, 1'b0);
      check("arst_valid", out_valid, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("arst_ready", in_ready, 1'b1);

      for (int k = 0; k < 1500; k++) begin
         v = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 15) == 0);
         if (fl) rdy = 1'b0;
         cycle(v, rand_instr(), $urandom & 32'hFFFF_FFFC, rdy, fl);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered RV32 instruction-decode stage. It accepts fetched instructions over a valid/ready handshake and decodes opcode, funct3 and funct7 into the datapath control bundle. It flags illegal encodings and holds the result in a one-entry ID/EX pipeline register. It also interlocks issue for a configurable number of cycles after a multiply/divide op is handed to execute. It sits between fetch and the execute stage and supersedes the purely combinational main decoder.

## Interface
- XLEN, 32, width of pc
- MULDIV_CYCLES, 4, cycles the execute mul/div unit stays busy after accepting an op (>=1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- pc_in  in  XLEN  instruction address
- flush  in  1  discard the held instruction (branch mispredict/trap)
- out_valid  out  1  control bundle valid
- out_ready  in  1  execute accepts the bundle
- RegWrite, ALUSrc, MemWrite, Branch, Jump, Jalr, ALUASrcPC, MulDiv, Illegal  out  1 each
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ResultSrc  out  2  00 ALU, 01 memory, 10 PC+4
- ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 upper-immediate
- funct3  out  3; funct7b5  out  1; rd, rs1, rs2  out  5 each; pc_out  out  XLEN
- md_busy  out  1  interlock active

## Operation
- Decode per opcode: load, store, R, I-ALU, branch, jal, jalr, lui, auipc.
- Load: ResultSrc=01. jal and jalr: ResultSrc=10, Jump=1. jalr: Jalr=1, ALUSrc=1, ImmSrc=I.
- lui and auipc: ImmSrc=U, ALUOp=11. auipc: ALUASrcPC=1. Other ops follow the standard RV32I single-cycle control.
- R-type funct7 legality:
  - 0000000 is legal for all funct3.
  - 0100000 is legal only for funct3 000 and 101.
  - 0000001 is legal and sets MulDiv=1 only when M support is compiled in.
- Illegal: unknown opcode, or an illegal funct7 as above. Output is Illegal=1 with all other control bits 0 and out_valid still asserted, so trap logic sees it.
- in_ready = !md_busy && (!out_valid || out_ready).
- Accept (in_valid && in_ready): the bundle, funct and register fields, and pc_in are registered, and out_valid=1 on the next cycle.
- Handoff (out_valid && out_ready), no new accept: out_valid clears.
- Handoff and accept in the same cycle: the new bundle replaces the old with no bubble.
- Interlock FSM, IDLE -> MD_BUSY on handoff of a bundle with MulDiv=1.
  - On entry the counter loads MULDIV_CYCLES-1.
  - The counter decrements each cycle; the FSM returns to IDLE on the cycle the counter reads 0.
  - md_busy=1 in MD_BUSY, which forces in_ready=0.
- flush: clears out_valid the next cycle and blocks an accept in the same cycle (in_ready is ignored). It does not alter MD_BUSY or the counter, because the mul/div unit is already committed.
- Counter width: clog2(MULDIV_CYCLES)+1. MULDIV_CYCLES=1 gives exactly one busy cycle.

## Timing
- Reset (async assert, sync-released use): out_valid=0, FSM=IDLE, counter=0, md_busy=0. All bundle outputs, Illegal, fields and pc_out reset to 0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle when no mul/div ops are present.
- Stall: while out_valid && !out_ready, all outputs hold stable.
- Mul/div handoff at cycle t: in_ready=0 from t+1 through t+MULDIV_CYCLES, and accepts resume at t+MULDIV_CYCLES+1.
- Reset asserted mid-MD_BUSY: the FSM aborts to IDLE immediately.

## Configuration
- DECODE_M_EXT_EN defined: funct7=0000001 R-type ops are legal, set MulDiv=1 and trigger the interlock.
- Undefined: such ops are Illegal, MulDiv is tied 0, and the FSM/counter logic is optimised away (md_busy tied 0).

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - ImmSrc, ResultSrc and ALUOp encodings;
  - the control-bundle struct typedef.
- Sub-module ctrl_decode: purely combinational instr -> bundle + Illegal. The stage wraps it with the handshake register and the interlock FSM.

## Test plan
- Load decode: reset, then instr 0x00812283 (lw x5,8(x2)). Expect next cycle: out_valid=1, RegWrite=1, ALUSrc=1, ResultSrc=01, ImmSrc=000, rd=5, rs1=2.
- Back-to-back, no bubbles: 0x003100B3 (add), then 0x000000EF (jal x1), then 0x00001097 (auipc x1,1), with out_ready=1.
  - add: ALUOp=10.
  - jal: Jump=1, ResultSrc=10, ImmSrc=011.
  - auipc: ALUASrcPC=1, ImmSrc=100.
- Illegal: 0x00000000, and 0x403170B3 (funct7 0100000 with funct3 111). Expect Illegal=1, all other control 0, out_valid=1.
- Mul/div with the macro defined and MULDIV_CYCLES=4: 0x023100B3 (mul). Expect MulDiv=1; after handoff, in_ready=0 for exactly 4 cycles. With the macro undefined, expect Illegal=1.
- Backpressure and flush: hold out_ready=0 for 3 cycles, expect outputs stable and in_ready=0. Then assert flush with in_valid=1, expect out_valid=0 next cycle and nothing accepted.
- Async reset mid-MD_BUSY: expect md_busy=0 and out_valid=0 immediately; in_ready=1 after release.
